gpio_avalon_bidir: RTL and testbench
====================================

Name: gpio_avalon_bidir

Overview:
- Parametrised successor to the team's fixed 32-bit output-only Avalon-MM PIO.
- Adds configurable width, per-bit direction, synchronised input readback, per-bit edge capture and a maskable level interrupt.
- Sits on the system Avalon-MM interconnect as a slave with zero-wait-state reads; pins connect to a top-level tri-state buffer (gpio_out/gpio_oe) and to input pads (gpio_in).

Parameters:
- WIDTH, 32, number of GPIO bits, legal range 1..32.
- RESET_OUT, 0, reset value of the output data register (WIDTH bits).
- RESET_DIR, 0, reset value of the direction register; 1 = output.
- EDGE_TYPE, 0, capture condition: 0 = rising, 1 = falling, 2 = any edge.
- SYNC_STAGES, 2, input synchroniser depth, legal range 2..3.

Ports:
- clk  in  1  system clock; all state is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  3  word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data; bits [31:WIDTH] ignored.
- readdata  out  32  combinational read data; bits [31:WIDTH] always 0.
- gpio_in  in  WIDTH  asynchronous pad inputs.
- gpio_out  out  WIDTH  output data register.
- gpio_oe  out  WIDTH  direction register; 1 = drive.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async, reset_n=0):
  - data_out=RESET_OUT, dir=RESET_DIR, irq_mask=0, edge_cap=0.
  - All synchroniser and previous-value flops = 0.
  - Outputs follow immediately: gpio_out=RESET_OUT, gpio_oe=RESET_DIR, irq=0.
- Write condition: chipselect && !write_n. The target register updates on that clk edge.
- Register map:
  - 0 DATA: write sets data_out; read returns in_sync (synchronised pin state, all bits regardless of dir).
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns edge_cap; write-1-to-clear per bit.
  - 4 OUTSET, 5 OUTCLEAR: optional, see below.
  - 6–7: reserved; read 0, writes ignored.
- Read path: readdata is a pure function of address and current register values. Zero latency; no read strobe; reads have no side effects.
- Synchroniser: SYNC_STAGES flops per bit; in_sync is the last stage. in_prev is in_sync delayed one cycle.
- Edge detect:
  - rising: in_sync & ~in_prev
  - falling: ~in_sync & in_prev
  - any: in_sync ^ in_prev
- Capture: edge_cap <= (edge_cap & ~clr) | edge, where clr is the W1C write mask.
  - A new edge in the same cycle as a clear of that bit leaves the bit set (set wins).
- Latency: a pad transition present before edge k sets edge_cap at edge k+SYNC_STAGES. DATA readback reflects it after edge k+SYNC_STAGES-1.
- Edges are captured on all bits independent of dir, so output bits looped back by the pad also capture.
- irq = |(edge_cap & irq_mask), combinational from registers and glitch-free as a function of flops.
  - Unmasking an already-captured bit asserts irq on the cycle after the mask write.
- Reset mid-operation: in-flight synchroniser state is discarded; the first post-reset cycle performs no edge detection because in_prev = in_sync = 0.
  - A pad held high through reset therefore produces one rising edge SYNC_STAGES cycles after release. This is required behaviour.

Optional Feature:
- Macro: GPIO_OUTSETCLR_EN.
- Defined:
  - Offset 4 OUTSET: data_out <= data_out | writedata.
  - Offset 5 OUTCLEAR: data_out <= data_out & ~writedata.
  - Both read 0. Atomic bit manipulation without read-modify-write.
- Undefined: offsets 4 and 5 are reserved (read 0, writes ignored); no extra logic.

Decomposition:
- Package gpio_pkg:
  - Register offset constants: GPIO_REG_DATA=0, GPIO_REG_DIR=1, GPIO_REG_MASK=2, GPIO_REG_EDGE=3, GPIO_REG_SET=4, GPIO_REG_CLR=5.
  - Edge-type constants: GPIO_EDGE_RISE=0, GPIO_EDGE_FALL=1, GPIO_EDGE_ANY=2.
- Sub-module gpio_sync: WIDTH-wide, SYNC_STAGES-deep synchroniser bank with async active-low reset; the only instantiation in the block.

Test Plan:
- Reset with RESET_OUT=32'hA5A5_0000, RESET_DIR=32'hFFFF_0000 -> gpio_out=A5A50000, gpio_oe=FFFF0000, irq=0, all four register reads match their reset values.
- Write DATA=32'h1234_5678, read DIR/MASK -> gpio_out=12345678 next cycle; other registers unchanged; write with chipselect=0 has no effect.
- EDGE_TYPE=0, SYNC_STAGES=2: gpio_in[3] 0->1 before edge k -> edge_cap[3]=1 at edge k+2; a 1->0 transition does not capture; irq stays 0 with mask=0; writing MASK=8 -> irq=1 next cycle.
- Write EDGE_CAP=32'h8 in the same cycle a new rising edge on bit 3 is detected -> bit 3 remains 1. A clear with no coincident edge -> bit 3 = 0 and irq = 0.
- GPIO_OUTSETCLR_EN defined, data_out=32'h0F0F_0F0F: write OUTSET=32'hF000_0000 -> FF0F0F0F; write OUTCLEAR=32'h0000_000F -> FF0F0F00. Macro undefined -> same writes leave data_out unchanged.
- WIDTH=8: write DATA=32'hFFFF_FFAB -> gpio_out=8'hAB; read any register -> readdata[31:8]=0. Reads at offsets 6 and 7 return 0.

Source files
------------

// File: rtl/gpio_avalon_bidir_pkg.sv
// Shared constants for the bidirectional Avalon-MM GPIO: register offsets and
// edge-capture selectors.
package gpio_pkg;
  localparam logic [2:0] GPIO_REG_DATA = 3'd0;
  localparam logic [2:0] GPIO_REG_DIR  = 3'd1;
  localparam logic [2:0] GPIO_REG_MASK = 3'd2;
  localparam logic [2:0] GPIO_REG_EDGE = 3'd3;
  localparam logic [2:0] GPIO_REG_SET  = 3'd4;
  localparam logic [2:0] GPIO_REG_CLR  = 3'd5;

  localparam int GPIO_EDGE_RISE = 0;
  localparam int GPIO_EDGE_FALL = 1;
  localparam int GPIO_EDGE_ANY  = 2;
endpackage

// File: rtl/gpio_avalon_bidir_if.sv
// Avalon-MM slave bus bundle for the GPIO block (zero-wait-state, no read strobe).
interface gpio_avalon_bidir_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/gpio_avalon_bidir_sync.sv
// WIDTH-wide, STAGES-deep flop synchroniser bank for asynchronous pad inputs.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] stg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];
endmodule

// File: rtl/gpio_avalon_bidir.sv
// Parametrised Avalon-MM GPIO with per-bit direction, synchronised readback,
// edge capture and a maskable level irq. Define GPIO_OUTSETCLR_EN for OUTSET/OUTCLEAR.
module gpio_avalon_bidir
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0,
  parameter int               EDGE_TYPE   = GPIO_EDGE_RISE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  gpio_avalon_bidir_if.slave  bus,
  input  logic [WIDTH-1:0]    gpio_in,
  output logic [WIDTH-1:0]    gpio_out,
  output logic [WIDTH-1:0]    gpio_oe,
  output logic                irq
);
  logic [WIDTH-1:0] data_out, dir, irq_mask, edge_cap;
  logic [WIDTH-1:0] in_sync, in_prev, edge_det, clr, wd;
  logic [31:0]      rdata;
  logic             wr;

  gpio_sync #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (gpio_in),
    .q       (in_sync)
  );

  assign wr  = bus.chipselect && !bus.write_n;
  assign wd  = bus.writedata[WIDTH-1:0];
  assign clr = (wr && bus.address == GPIO_REG_EDGE) ? wd : '0;

  always_comb begin
    case (EDGE_TYPE)
      GPIO_EDGE_RISE: edge_det = in_sync & ~in_prev;
      GPIO_EDGE_FALL: edge_det = ~in_sync & in_prev;
      default:        edge_det = in_sync ^ in_prev;
    endcase
  end

  // Set wins over a coincident W1C clear of the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irq_mask <= '0;
      edge_cap <= '0;
      in_prev  <= '0;
    end else begin
      in_prev  <= in_sync;
      edge_cap <= (edge_cap & ~clr) | edge_det;
      if (wr) begin
        case (bus.address)
          GPIO_REG_DATA: data_out <= wd;
          GPIO_REG_DIR:  dir      <= wd;
          GPIO_REG_MASK: irq_mask <= wd;
`ifdef GPIO_OUTSETCLR_EN
          GPIO_REG_SET:  data_out <= data_out | wd;
          GPIO_REG_CLR:  data_out <= data_out & ~wd;
`endif
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.address)
      GPIO_REG_DATA: rdata[WIDTH-1:0] = in_sync;
      GPIO_REG_DIR:  rdata[WIDTH-1:0] = dir;
      GPIO_REG_MASK: rdata[WIDTH-1:0] = irq_mask;
      GPIO_REG_EDGE: rdata[WIDTH-1:0] = edge_cap;
      default: ;
    endcase
  end

  assign bus.readdata = rdata;
  assign gpio_out     = data_out;
  assign gpio_oe      = dir;
  assign irq          = |(edge_cap & irq_mask);
endmodule

// File: tb/tb_gpio_avalon_bidir.sv
// Directed self-checking bench: a 32-bit rising-edge instance and an 8-bit instance.
module tb_gpio_avalon_bidir;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] gpio_in_a = '0;
  logic [31:0] gpio_out_a, gpio_oe_a;
  logic        irq_a;
  logic [7:0]  gpio_in_b = '0;
  logic [7:0]  gpio_out_b, gpio_oe_b;
  logic        irq_b;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_set, exp_clr;

  gpio_avalon_bidir_if bus_a ();
  gpio_avalon_bidir_if bus_b ();

  always #5 clk = ~clk;

  gpio_avalon_bidir #(
    .WIDTH(32), .RESET_OUT(32'hA5A5_0000), .RESET_DIR(32'hFFFF_0000),
    .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a.slave),
    .gpio_in(gpio_in_a), .gpio_out(gpio_out_a), .gpio_oe(gpio_oe_a), .irq(irq_a)
  );

  gpio_avalon_bidir #(
    .WIDTH(8), .RESET_OUT(8'h00), .RESET_DIR(8'h00),
    .EDGE_TYPE(2), .SYNC_STAGES(3)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b.slave),
    .gpio_in(gpio_in_b), .gpio_out(gpio_out_b), .gpio_oe(gpio_oe_b), .irq(irq_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [2:0] a, input logic [31:0] d);
    bus_a.address = a; bus_a.writedata = d; bus_a.chipselect = 1'b1; bus_a.write_n = 1'b0;
    tick(1);
    bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1;
  endtask

  task automatic wr_b(input logic [2:0] a, input logic [31:0] d);
    bus_b.address = a; bus_b.writedata = d; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0;
    tick(1);
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1;
  endtask

  task automatic rd_a(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus_a.address = a; #1;
    chk(tag, bus_a.readdata, exp);
  endtask

  task automatic rd_b(input string tag, input logic [2:0] a, input logic [31:0] exp);
    bus_b.address = a; #1;
    chk(tag, bus_b.readdata, exp);
  endtask

  initial begin
    bus_a.address = '0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
`ifdef GPIO_OUTSETCLR_EN
    exp_set = 32'hFF0F_0F0F; exp_clr = 32'hFF0F_0F00;
`else
    exp_set = 32'h0F0F_0F0F; exp_clr = 32'h0F0F_0F0F;
`endif

    // Reset values
    #12;
    chk("rst_gpio_out", gpio_out_a, 32'hA5A5_0000);
    chk("rst_gpio_oe",  gpio_oe_a,  32'hFFFF_0000);
    chk("rst_irq",      {31'b0, irq_a}, 32'h0);
    rd_a("rst_rd_data", 3'd0, 32'h0);
    rd_a("rst_rd_dir",  3'd1, 32'hFFFF_0000);
    rd_a("rst_rd_mask", 3'd2, 32'h0);
    rd_a("rst_rd_edge", 3'd3, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // DATA write, other registers untouched, unselected write ignored
    wr_a(3'd0, 32'h1234_5678);
    chk("data_wr_out", gpio_out_a, 32'h1234_5678);
    rd_a("data_wr_dir",  3'd1, 32'hFFFF_0000);
    rd_a("data_wr_mask", 3'd2, 32'h0);
    bus_a.address = 3'd0; bus_a.writedata = 32'h0; bus_a.write_n = 1'b0; bus_a.chipselect = 1'b0;
    tick(1);
    bus_a.write_n = 1'b1;
    chk("nocs_out", gpio_out_a, 32'h1234_5678);

    // Rising edge on bit 3: readback after k+1, capture at k+2
    gpio_in_a[3] = 1'b1;
    tick(1);
    rd_a("sync_k0_data", 3'd0, 32'h0);
    tick(1);
    rd_a("sync_k1_data", 3'd0, 32'h8);
    rd_a("sync_k1_edge", 3'd3, 32'h0);
    tick(1);
    rd_a("cap_k2_edge", 3'd3, 32'h8);
    chk("cap_irq_masked", {31'b0, irq_a}, 32'h0);
    gpio_in_a[3] = 1'b0;
    tick(4);
    rd_a("fall_no_cap", 3'd3, 32'h8);
    chk("fall_irq_masked", {31'b0, irq_a}, 32'h0);
    wr_a(3'd2, 32'h8);
    chk("unmask_irq", {31'b0, irq_a}, 32'h1);

    // W1C coincident with a new edge: set wins
    gpio_in_a[3] = 1'b1;
    tick(2);
    wr_a(3'd3, 32'h8);
    rd_a("clr_vs_edge", 3'd3, 32'h8);
    chk("clr_vs_edge_irq", {31'b0, irq_a}, 32'h1);
    wr_a(3'd3, 32'h8);
    rd_a("clr_alone", 3'd3, 32'h0);
    chk("clr_alone_irq", {31'b0, irq_a}, 32'h0);

    // OUTSET / OUTCLEAR
    wr_a(3'd0, 32'h0F0F_0F0F);
    wr_a(3'd4, 32'hF000_0000);
    chk("outset", gpio_out_a, exp_set);
    wr_a(3'd5, 32'h0000_000F);
    chk("outclr", gpio_out_a, exp_clr);
    rd_a("rd_off4", 3'd4, 32'h0);
    rd_a("rd_off5", 3'd5, 32'h0);

    // Reserved offsets
    wr_a(3'd6, 32'hFFFF_FFFF);
    wr_a(3'd7, 32'hFFFF_FFFF);
    chk("resv_wr_out", gpio_out_a, exp_clr);
    rd_a("rd_off6", 3'd6, 32'h0);
    rd_a("rd_off7", 3'd7, 32'h0);

    // Narrow instance: upper bits ignored on write and zero on read
    wr_b(3'd0, 32'hFFFF_FFAB);
    chk("b_gpio_out", {24'h0, gpio_out_b}, 32'h0000_00AB);
    wr_b(3'd1, 32'hFFFF_FFFF);
    rd_b("b_rd_dir", 3'd1, 32'h0000_00FF);
    gpio_in_b = 8'h5A;
    tick(3);
    rd_b("b_rd_data", 3'd0, 32'h0000_005A);
    rd_b("b_rd_edge_any", 3'd3, 32'h0);
    tick(1);
    rd_b("b_edge_any_cap", 3'd3, 32'h0000_005A);
    rd_b("b_rd_off6", 3'd6, 32'h0);
    rd_b("b_rd_off7", 3'd7, 32'h0);

    // Pad held high through reset yields one rising edge after release
    gpio_in_a = 32'h1;
    tick(2);
    reset_n = 1'b0;
    #1;
    rd_a("midrst_edge", 3'd3, 32'h0);
    chk("midrst_out", gpio_out_a, 32'hA5A5_0000);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    rd_a("postrst_k0_data", 3'd0, 32'h0);
    tick(1);
    rd_a("postrst_k1_edge", 3'd3, 32'h0);
    tick(1);
    rd_a("postrst_k2_edge", 3'd3, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
